seq_detector_prog: RTL and testbench

- Programmable serial bit-sequence detector. Generalises the fixed 7-bit pattern detector to a runtime-loadable pattern of 1..MAX_LEN bits.
- Adds selectable overlapping or non-overlapping detection, a bit-valid qualifier and a saturating match counter.
- Sits on a serial data path. Consumes one bit per enabled clock and pulses `match` when the last LEN accepted bits equal the programmed pattern.

---
 rtl/seq_detector_prog_if.sv | 28 ++
 rtl/seq_detector_prog.sv | 96 +++++++++
 tb/tb_seq_detector_prog.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seq_detector_prog_if.sv
// Bit-stream, configuration and status bundle for the programmable sequence detector.
// The driver of the stream and configuration uses master; the detector uses slave.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               en;
  logic               x;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   len_q;

  modport master (
    output en, x, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_count, len_q
  );

  modport slave (
    input  en, x, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, match_count, len_q
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable serial sequence detector with a runtime-loadable 1..MAX_LEN bit pattern,
// overlap selection, a bit-valid qualifier and a saturating match counter.
module seq_detector_prog #(
  parameter int               MAX_LEN     = 8,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0110_1100),
  parameter int               DEF_LEN     = 7,
  parameter logic             DEF_OVERLAP = 1'b1,
  localparam int              LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_prog_if.slave bus
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;
  logic               match_q,   match_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [MAX_LEN-1:0] hist_sh;
  logic [LEN_W-1:0]   fill_sh;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  // Only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    match_d   = 1'b0;
    hit       = 1'b0;
    hist_sh   = {hist_q[MAX_LEN-2:0], bus.x};
    fill_sh   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    if (bus.cfg_we) begin
      pattern_d = bus.cfg_pattern;
      overlap_d = bus.cfg_overlap;
      len_d     = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
      hist_d    = '0;
      fill_d    = '0;
    end else if (bus.en) begin
      hit     = (len_q != '0) && (fill_sh >= len_q) &&
                (((hist_sh ^ pattern_q) & mask) == '0);
      hist_d  = hist_sh;
      fill_d  = (hit && !overlap_q) ? '0 : fill_sh;
      match_d = hit;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.len_q       = len_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: hand-computed match/count/length expectations.
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic b);
    bus.en = e;
    bus.x  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input string tag, input int n,
                            input logic [15:0] bits, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i]);
      chk($sformatf("%s bit%0d match", tag, i + 1), bus.match, exp[n-1-i]);
    end
  endtask

  // The bit offered alongside cfg_we must be discarded.
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    step(1'b1, 1'b1);
    bus.cfg_we = 1'b0;
    chk("cfg match", bus.match, 0);
  endtask

  task automatic clr();
    bus.cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    bus.cnt_clr = 1'b0;
  endtask

  initial begin
    bus.en = 0; bus.x = 0; bus.cfg_we = 0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.cfg_overlap = 0; bus.cnt_clr = 0;
    rst = 1'b1;
    #8;
    chk("reset match", bus.match, 0);
    chk("reset count", bus.match_count, 0);
    chk("reset len", bus.len_q, 7);
    #4 rst = 1'b0;

    // 1: default pattern 1101100, overlapping
    run_stream("t1", 14, 16'(14'b11011001101100), 16'(14'b00000010000001));
    chk("t1 count", bus.match_count, 2);

    // 2: pattern 1011, overlap then non-overlap
    cfg(8'b0000_1011, 4'd4, 1'b1);
    chk("t2 cfg keeps count", bus.match_count, 2);
    clr();
    chk("t2 clr count", bus.match_count, 0);
    run_stream("t2ov", 7, 16'(7'b1011011), 16'(7'b0001001));
    chk("t2ov count", bus.match_count, 2);
    cfg(8'b0000_1011, 4'd4, 1'b0);
    clr();
    run_stream("t2no", 7, 16'(7'b1011011), 16'(7'b0001000));
    chk("t2no count", bus.match_count, 1);

    // 3: gaps with en=0 are transparent
    cfg(8'b0110_1100, 4'd7, 1'b1);
    clr();
    run_stream("t3a", 3, 16'(3'b110), 16'(3'b000));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0]);
      chk($sformatf("t3 gap%0d match", i), bus.match, 0);
    end
    run_stream("t3b", 4, 16'(4'b1100), 16'(4'b0001));
    chk("t3 count", bus.match_count, 1);

    // 4: counter saturation, clear beats a coincident hit
    cfg(8'b0000_0011, 4'd2, 1'b1);
    clr();
    run_stream("t4", 6, 16'(6'b111111), 16'(6'b011111));
    chk("t4 sat count", bus.match_count, 3);
    bus.cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    bus.cnt_clr = 1'b0;
    chk("t4 clr+hit match", bus.match, 1);
    chk("t4 clr+hit count", bus.match_count, 0);
    step(1'b1, 1'b1);
    chk("t4 after clr count", bus.match_count, 1);

    // 5: length clamp, then length zero disables detection
    cfg(8'hFF, 4'd12, 1'b1);
    chk("t5 clamp len", bus.len_q, 8);
    run_stream("t5full", 8, 16'(8'hFF), 16'(8'b00000001));
    chk("t5 count", bus.match_count, 2);
    cfg(8'hFF, 4'd0, 1'b1);
    chk("t5 zero len", bus.len_q, 0);
    run_stream("t5zero", 10, 16'(10'h3FF), 16'h0000);
    chk("t5 zero count", bus.match_count, 2);

    // 6: asynchronous reset mid-sequence
    cfg(8'b0110_1100, 4'd7, 1'b1);
    chk("t6 pre count", bus.match_count, 2);
    run_stream("t6a", 5, 16'(5'b11011), 16'h0000);
    #3 rst = 1'b1;
    #1;
    chk("t6 async count", bus.match_count, 0);
    chk("t6 async match", bus.match, 0);
    chk("t6 async len", bus.len_q, 7);
    #2 rst = 1'b0;
    run_stream("t6b", 2, 16'(2'b00), 16'h0000);
    run_stream("t6c", 7, 16'(7'b1101100), 16'(7'b0000001));
    chk("t6 count", bus.match_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
